// File: rtl/led_bank_arbiter_pkg.sv
// Shared definitions for the LED bank blocks: FSM state encoding, LED bus width
// and the active-high to active-low pin conversion.
package led_bank_arbiter_pkg;

  localparam int               LED_W       = 8;
  localparam logic [LED_W-1:0] LED_ALL_OFF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // The pins are active-low, so a lit pattern bit drives its pin to 0.
  function automatic logic [LED_W-1:0] to_pins(input logic [LED_W-1:0] pattern);
    return pattern ^ LED_ALL_OFF;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_ms_tick_gen.sv
// Free-running prescaler that produces a one-cycle tick every PRESCALE clocks.
// Shared by the LED blocks as their millisecond time base.
module ms_tick_gen #(
  parameter int PRESCALE = 133000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == CNT_W'(PRESCALE - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing the board LED bank between NREQ pattern sources,
// with a minimum visible hold time and a contention-only maximum hold time.
module led_bank_arbiter
  import led_bank_arbiter_pkg::*;
#(
  parameter int               NREQ       = 4,
  parameter int               PRESCALE   = 133000,
  parameter int               HOLD_MS    = 250,
  parameter int               TIMEOUT_MS = 2000,
  parameter logic [LED_W-1:0] IDLE_PAT   = 8'h00
) (
  input  logic                  osc_clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LED_W-1:0] pat,
  output logic [NREQ-1:0]       gnt,
  output logic [LED_W-1:0]      LED,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int MS_W  = $clog2(TIMEOUT_MS + 1);

  logic                        r_rst_sync;
  logic                        w_rst_n;
  logic                        w_tick;
  logic [NREQ-1:0][LED_W-1:0]  w_pats;

  state_t                      r_state,  w_state_nxt;
  logic [NREQ-1:0]             r_gnt,    w_gnt_nxt;
  logic [LED_W-1:0]            r_led,    w_led_nxt;
  logic [IDX_W-1:0]            r_owner,  w_owner_nxt;
  logic [IDX_W-1:0]            r_rr_ptr, w_rr_nxt;
  logic [MS_W-1:0]             r_ms_cnt, w_ms_nxt;
  logic [IDX_W-1:0]            w_winner;
  logic [NREQ-1:0]             w_owner_oh;
  logic                        w_release;

  // First set request at or after ptr, wrapping; ptr itself when none is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [IDX_W-1:0] ptr);
    logic found;
    int   idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && r[idx]) begin
        found   = 1'b1;
        rr_pick = IDX_W'(idx);
      end
    end
  endfunction

  // Assertion is immediate through the async clear; release waits for a clock edge.
  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 1'b0;
    else        r_rst_sync <= 1'b1;
  end
  assign w_rst_n = r_rst_sync;

  ms_tick_gen #(.PRESCALE(PRESCALE)) u_ms_tick_gen (
    .clk    (osc_clk),
    .rst_n  (w_rst_n),
    .o_tick (w_tick)
  );

  assign w_pats     = pat;
  assign w_winner   = rr_pick(req, r_rr_ptr);
  assign w_owner_oh = NREQ'(1) << r_owner;
  assign w_release  = (!req[r_owner] && (r_ms_cnt >= MS_W'(HOLD_MS))) ||
                      ((r_ms_cnt >= MS_W'(TIMEOUT_MS)) && |(req & ~w_owner_oh));

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_led_nxt   = r_led;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_ms_nxt    = r_ms_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_winner;
          w_gnt_nxt   = NREQ'(1) << w_winner;
          w_led_nxt   = to_pins(w_pats[w_winner]);
          w_ms_nxt    = '0;
        end else begin
          w_led_nxt   = to_pins(IDLE_PAT);
        end
      end
      ST_GRANT: begin
        if (w_tick && (r_ms_cnt != MS_W'(TIMEOUT_MS)))
          w_ms_nxt = r_ms_cnt + 1'b1;
        // Once the owner drops its request the last shown pattern stays frozen.
        if (req[r_owner])
          w_led_nxt = to_pins(w_pats[r_owner]);
        if (w_release) begin
          w_state_nxt = ST_RELEASE;
          w_gnt_nxt   = '0;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_rr_nxt    = (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge osc_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_led    <= to_pins(IDLE_PAT);
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_ms_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_led    <= w_led_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_ms_cnt <= w_ms_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign LED  = r_led;
  assign busy = (r_state != ST_IDLE);

endmodule
